serial_add_sub: RTL and testbench



---
 rtl/arith_pkg.sv | 16 +
 rtl/serial_fa_cell.sv | 17 +
 rtl/serial_add_sub.sv | 123 ++++++++++++
 tb/tb_serial_add_sub.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: controller state encoding and operation codes
// for the bit-serial adder/subtractor.
package arith_pkg;

  // Controller states of the bit-serial engine.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Operation select encoding for the op input.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage : arith_pkg

// File: rtl/serial_fa_cell.sv
// One-bit combinational full adder; the single arithmetic cell reused on
// every bit of a serial operation.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and carry of three input bits.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (cin & (a ^ b));
  end

endmodule : serial_fa_cell

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor. Operands are latched in parallel,
// processed LSB first through one full-adder cell and a carry flop, and the
// result plus carry/overflow flags are registered when the last bit is done.
// Subtraction is a + ~b + 1: operand B is inverted at load and the carry flop
// is preset to 1.
module serial_add_sub
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t state_reg;
  state_t state_next;

  logic [WIDTH-1:0] a_shift;
  logic [WIDTH-1:0] b_shift;
  // Bits already produced; the bit computed this cycle is appended on top,
  // so only WIDTH-1 bits need storage.
  logic [WIDTH-2:0] sum_shift;
  logic             carry_reg;
  logic [CNT_W-1:0] bit_cnt;

  logic             cell_s;
  logic             cell_c;
  logic [WIDTH-1:0] sum_merged;
  logic             accept;
  logic             last_bit;

  serial_fa_cell u_cell (
    .a    (a_shift[0]),
    .b    (b_shift[0]),
    .cin  (carry_reg),
    .s    (cell_s),
    .cout (cell_c)
  );

  // Handshake qualifiers and the sum vector including the current bit.
  always_comb begin
    accept     = start && ((state_reg == IDLE) || (state_reg == DONE));
    last_bit   = (state_reg == SHIFT) && (bit_cnt == LAST_BIT);
    sum_merged = {cell_s, sum_shift};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: start is honoured only when not shifting.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = start ? SHIFT : IDLE;
      SHIFT:   state_next = (bit_cnt == LAST_BIT) ? DONE : SHIFT;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    busy = (state_reg == SHIFT);
    done = (state_reg == DONE);
  end

  // Operand shift registers, carry flop and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_shift   <= '0;
      b_shift   <= '0;
      sum_shift <= '0;
      carry_reg <= 1'b0;
      bit_cnt   <= '0;
    end else if (accept) begin
      a_shift   <= a;
      b_shift   <= (op == OP_SUB) ? ~b : b;
      sum_shift <= '0;
      carry_reg <= op;
      bit_cnt   <= '0;
    end else if (state_reg == SHIFT) begin
      a_shift   <= {1'b0, a_shift[WIDTH-1:1]};
      b_shift   <= {1'b0, b_shift[WIDTH-1:1]};
      sum_shift <= sum_merged[WIDTH-1:1];
      carry_reg <= cell_c;
      bit_cnt   <= bit_cnt + CNT_W'(1);
    end
  end

  // Result and flags load on the final bit and then hold. On that edge the
  // carry flop still holds the carry into the MSB, so it serves as the saved
  // MSB carry-in for the overflow test.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (last_bit) begin
      result    <= sum_merged;
      carry_out <= cell_c;
      overflow  <= carry_reg ^ cell_c;
    end
  end

endmodule : serial_add_sub

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub (WIDTH=8): directed scenarios plus
// randomized operations compared with an integer-arithmetic reference model.
module tb_serial_add_sub;
  import arith_pkg::*;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  task automatic model(input logic [7:0] x, input logic [7:0] y, input logic o,
                       output logic [7:0] r, output logic co, output logic ov);
    int u;
    int s;
    if (o == OP_ADD) begin
      u  = int'(x) + int'(y);
      co = (u > 255);
      s  = int'($signed(x)) + int'($signed(y));
    end else begin
      u  = int'(x) - int'(y);
      co = (x >= y);
      s  = int'($signed(x)) - int'($signed(y));
    end
    r  = u[7:0];
    ov = (s > 127) || (s < -128);
  endtask

  // Pulse start with the given operands and wait (bounded) for done.
  // lat = edges from accept to the cycle where done is seen.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic o,
                        output int lat, output int busy_cycles, output bit overlap);
    a = x; b = y; op = o; start = 1'b1;
    tick;
    start = 1'b0;
    lat = -1; busy_cycles = 0; overlap = 1'b0;
    for (int i = 0; i < 4 * WIDTH; i++) begin
      if (busy) busy_cycles++;
      if (busy && done) overlap = 1'b1;
      if (done) begin
        lat = i;
        break;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if ({busy, done} !== 2'b00) $display("FAIL reset_status: got busy/done=%b required 00", {busy, done}); else n_pass++;
    n_checks++; if ({result, carry_out, overflow} !== 10'h0) $display("FAIL reset_outputs: got result=%h co=%b ov=%b required 0", result, carry_out, overflow); else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    tick;
    n_checks++; if ({busy, done} !== 2'b00) $display("FAIL idle_after_reset: got busy/done=%b required 00", {busy, done}); else n_pass++;
  endtask

  task automatic test_add_overflow;
    int lat; int bc; bit ovl;
    run_op(8'h5A, 8'h33, OP_ADD, lat, bc, ovl);
    $display("op 5a+33 -> result=%h co=%b ov=%b latency=%0d", result, carry_out, overflow, lat);
    n_checks++; if (lat !== WIDTH) $display("FAIL add_ovf_latency: got %0d required %0d", lat, WIDTH); else n_pass++;
    n_checks++; if (bc !== WIDTH) $display("FAIL add_ovf_busy_cycles: got %0d required %0d", bc, WIDTH); else n_pass++;
    n_checks++; if (ovl !== 1'b0) $display("FAIL busy_done_overlap: got %b required 0", ovl); else n_pass++;
    n_checks++; if (result !== 8'h8D) $display("FAIL add_ovf_result: got %h required 8d", result); else n_pass++;
    n_checks++; if ({carry_out, overflow} !== 2'b01) $display("FAIL add_ovf_flags: got co/ov=%b required 01", {carry_out, overflow}); else n_pass++;
    tick;
    n_checks++; if (done !== 1'b0) $display("FAIL done_one_cycle: got %b required 0", done); else n_pass++;
    n_checks++; if (result !== 8'h8D) $display("FAIL result_hold: got %h required 8d", result); else n_pass++;
  endtask

  task automatic test_add_wrap;
    int lat; int bc; bit ovl;
    run_op(8'hFF, 8'h01, OP_ADD, lat, bc, ovl);
    $display("op ff+01 -> result=%h co=%b ov=%b latency=%0d", result, carry_out, overflow, lat);
    n_checks++; if (result !== 8'h00) $display("FAIL add_wrap_result: got %h required 00", result); else n_pass++;
    n_checks++; if ({carry_out, overflow} !== 2'b10) $display("FAIL add_wrap_flags: got co/ov=%b required 10", {carry_out, overflow}); else n_pass++;
    tick;
  endtask

  task automatic test_sub_borrow;
    int lat; int bc; bit ovl;
    run_op(8'h10, 8'h20, OP_SUB, lat, bc, ovl);
    $display("op 10-20 -> result=%h co=%b ov=%b latency=%0d", result, carry_out, overflow, lat);
    n_checks++; if (result !== 8'hF0) $display("FAIL sub_borrow_result: got %h required f0", result); else n_pass++;
    n_checks++; if ({carry_out, overflow} !== 2'b00) $display("FAIL sub_borrow_flags: got co/ov=%b required 00", {carry_out, overflow}); else n_pass++;
    tick;
    run_op(8'h80, 8'h01, OP_SUB, lat, bc, ovl);
    $display("op 80-01 -> result=%h co=%b ov=%b latency=%0d", result, carry_out, overflow, lat);
    n_checks++; if (result !== 8'h7F) $display("FAIL sub_ovf_result: got %h required 7f", result); else n_pass++;
    n_checks++; if ({carry_out, overflow} !== 2'b11) $display("FAIL sub_ovf_flags: got co/ov=%b required 11", {carry_out, overflow}); else n_pass++;
    tick;
  endtask

  task automatic test_reset_mid_op;
    int lat; int bc; bit ovl;
    bit stray_done;
    a = 8'h5A; b = 8'h33; op = OP_ADD; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    n_checks++; if (busy !== 1'b1) $display("FAIL midop_busy: got %b required 1", busy); else n_pass++;
    n_checks++; if ({result, carry_out, overflow} !== {8'h7F, 2'b11}) $display("FAIL midop_hold: got result=%h co=%b ov=%b required 7f/1/1", result, carry_out, overflow); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({busy, done} !== 2'b00) $display("FAIL async_reset_status: got busy/done=%b required 00", {busy, done}); else n_pass++;
    n_checks++; if ({result, carry_out, overflow} !== 10'h0) $display("FAIL async_reset_outputs: got result=%h co=%b ov=%b required 0", result, carry_out, overflow); else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    stray_done = 1'b0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      tick;
      if (done) stray_done = 1'b1;
    end
    n_checks++; if (stray_done !== 1'b0) $display("FAIL aborted_no_done: got %b required 0", stray_done); else n_pass++;
    run_op(8'h01, 8'h01, OP_ADD, lat, bc, ovl);
    $display("op 01+01 -> result=%h co=%b ov=%b latency=%0d", result, carry_out, overflow, lat);
    n_checks++; if (lat !== WIDTH) $display("FAIL post_reset_latency: got %0d required %0d", lat, WIDTH); else n_pass++;
    n_checks++; if (result !== 8'h02) $display("FAIL post_reset_result: got %h required 02", result); else n_pass++;
    tick;
  endtask

  // Start held high; second operands presented in the DONE cycle; junk
  // start/operands while shifting must not disturb anything. The second
  // accept happens on the edge ending the DONE cycle, so done pulses are
  // WIDTH+1 cycles apart.
  task automatic test_back_to_back;
    int t1 = -1;
    int t2 = -1;
    a = 8'h01; b = 8'h02; op = OP_ADD; start = 1'b1;
    tick;
    for (int i = 0; i < 6 * WIDTH && t2 < 0; i++) begin
      if (done) begin
        if (t1 < 0) begin
          t1 = i;
          $display("op 01+02 -> result=%h co=%b ov=%b latency=%0d", result, carry_out, overflow, i);
          n_checks++; if (result !== 8'h03) $display("FAIL b2b_first_result: got %h required 03", result); else n_pass++;
          a = 8'h03; b = 8'h04; op = OP_ADD; start = 1'b1;
        end else begin
          t2 = i;
          $display("op 03+04 -> result=%h co=%b ov=%b done_gap=%0d", result, carry_out, overflow, t2 - t1);
          n_checks++; if (result !== 8'h07) $display("FAIL b2b_second_result: got %h required 07", result); else n_pass++;
          start = 1'b0;
        end
      end else if (t1 >= 0) begin
        n_checks++; if (result !== 8'h03) $display("FAIL b2b_result_hold: got %h required 03", result); else n_pass++;
        start = 1'($urandom_range(0, 1));
        a = 8'($urandom); b = 8'($urandom); op = 1'($urandom_range(0, 1));
      end else if (i > 0) begin
        a = 8'hAA; b = 8'h55; op = OP_SUB;
      end
      tick;
    end
    start = 1'b0;
    n_checks++; if (t1 !== WIDTH) $display("FAIL b2b_first_latency: got %0d required %0d", t1, WIDTH); else n_pass++;
    n_checks++; if (t2 - t1 !== WIDTH + 1) $display("FAIL b2b_done_gap: got %0d required %0d", t2 - t1, WIDTH + 1); else n_pass++;
  endtask

  task automatic test_random;
    int lat; int bc; bit ovl;
    logic [7:0] x, y, er;
    logic o, eco, eov;
    for (int n = 0; n < 40; n++) begin
      x = 8'($urandom); y = 8'($urandom); o = 1'($urandom_range(0, 1));
      model(x, y, o, er, eco, eov);
      run_op(x, y, o, lat, bc, ovl);
      $display("op %h %s %h -> result=%h co=%b ov=%b latency=%0d", x, (o == OP_SUB) ? "-" : "+", y, result, carry_out, overflow, lat);
      n_checks++; if ({lat == WIDTH, bc == WIDTH, ovl} !== 3'b110) $display("FAIL rand_timing: got latency=%0d busy=%0d overlap=%b required %0d/%0d/0", lat, bc, ovl, WIDTH, WIDTH); else n_pass++;
      n_checks++; if ({result, carry_out, overflow} !== {er, eco, eov}) $display("FAIL rand_value: got %h/%b/%b required %h/%b/%b", result, carry_out, overflow, er, eco, eov); else n_pass++;
      // Sometimes start the next op straight from the DONE cycle.
      if ($urandom_range(0, 1) == 1) tick;
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_add_overflow;
    test_add_wrap;
    test_sub_borrow;
    test_reset_mid_op;
    test_back_to_back;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_serial_add_sub
